// File: rtl/lock_controller_p.sv
// Password lock controller: sequences the saver, deleter and comparator and tracks failed compares.
// Optional lockout after MAX_FAIL consecutive mismatches is enabled by defining LOCK_LOCKOUT_EN.
module lock_controller_p #(
    parameter int PW_LEN      = 4,
    parameter int CNT_W       = 3,
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter,
    input  logic             delete,
    input  logic             lock,
    input  logic [CNT_W-1:0] counter,
    input  logic             saver_done,
    input  logic             deleter_done,
    input  logic             comparator_done,
    input  logic             match,
    input  logic             error_open,
    output logic             save_start,
    output logic             delete_start,
    output logic             compare_start,
    output logic             unlock,
    output logic             error,
    output logic             locked_out,
    output logic [3:0]       fail_count
);

    typedef enum logic [2:0] {
        S_EMPTY,
        S_SAVE,
        S_OPEN,
        S_DELETE,
        S_LOCKED,
`ifdef LOCK_LOCKOUT_EN
        S_LOCKOUT,
`endif
        S_COMPARE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt_prev;
    logic             r_save_start, r_delete_start, r_compare_start;
    logic             r_unlock, r_error;
    logic [3:0]       r_fail_count;

    logic             w_full, w_edge;
    logic [3:0]       w_fail_next;

    assign w_full      = (counter == CNT_W'(PW_LEN));
    // Only a transition into a full buffer starts a compare; a held full buffer does not.
    assign w_edge      = w_full && (r_cnt_prev != CNT_W'(PW_LEN));
    assign w_fail_next = r_fail_count + 4'd1;

`ifdef LOCK_LOCKOUT_EN
    localparam int TW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
    logic [TW-1:0] r_timer;
    logic          r_locked_out;
    assign locked_out = r_locked_out;
`else
    assign locked_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_EMPTY;
            r_cnt_prev      <= '0;
            r_save_start    <= 1'b0;
            r_delete_start  <= 1'b0;
            r_compare_start <= 1'b0;
            r_unlock        <= 1'b0;
            r_error         <= 1'b0;
            r_fail_count    <= 4'd0;
`ifdef LOCK_LOCKOUT_EN
            r_timer         <= '0;
            r_locked_out    <= 1'b0;
`endif
        end else begin
            r_cnt_prev      <= counter;
            r_save_start    <= 1'b0;
            r_delete_start  <= 1'b0;
            r_compare_start <= 1'b0;
            r_error         <= 1'b0;
            case (r_state)
                S_EMPTY: begin
                    if (enter) begin
                        if (w_full) begin
                            r_state      <= S_SAVE;
                            r_save_start <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                S_SAVE: begin
                    if (saver_done) begin
                        r_state  <= S_OPEN;
                        r_unlock <= 1'b1;
                    end
                end
                S_OPEN: begin
                    r_error <= error_open;
                    if (lock && !error_open) begin
                        r_state  <= S_LOCKED;
                        r_unlock <= 1'b0;
                    end else if (delete && w_full) begin
                        r_state        <= S_DELETE;
                        r_delete_start <= 1'b1;
                        r_unlock       <= 1'b0;
                    end else if (enter && w_full) begin
                        r_state      <= S_SAVE;
                        r_save_start <= 1'b1;
                        r_unlock     <= 1'b0;
                    end
                end
                S_DELETE: begin
                    if (deleter_done) r_state <= S_EMPTY;
                end
                S_LOCKED: begin
                    if (w_edge) begin
                        r_state         <= S_COMPARE;
                        r_compare_start <= 1'b1;
                    end
                end
                S_COMPARE: begin
                    if (comparator_done) begin
                        if (match) begin
                            r_state      <= S_OPEN;
                            r_unlock     <= 1'b1;
                            r_fail_count <= 4'd0;
                        end else begin
`ifdef LOCK_LOCKOUT_EN
                            r_fail_count <= w_fail_next;
                            if (w_fail_next == 4'(MAX_FAIL)) begin
                                r_state      <= S_LOCKOUT;
                                r_locked_out <= 1'b1;
                                r_timer      <= TW'(LOCKOUT_CYC - 1);
                            end else begin
                                r_state <= S_LOCKED;
                            end
`else
                            r_fail_count <= (r_fail_count == 4'd15) ? 4'd15 : w_fail_next;
                            r_state      <= S_LOCKED;
`endif
                        end
                    end
                end
`ifdef LOCK_LOCKOUT_EN
                S_LOCKOUT: begin
                    // Timer is loaded with LOCKOUT_CYC-1, so locked_out spans exactly LOCKOUT_CYC cycles.
                    if (r_timer == '0) begin
                        r_state      <= S_LOCKED;
                        r_locked_out <= 1'b0;
                        r_fail_count <= 4'd0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
`endif
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign save_start    = r_save_start;
    assign delete_start  = r_delete_start;
    assign compare_start = r_compare_start;
    assign unlock        = r_unlock;
    assign error         = r_error;
    assign fail_count    = r_fail_count;

endmodule

// File: doc/lock_controller_p.md
LOCK_CONTROLLER_P -- requirements
Module: lock_controller_p

Interface
REQ-001 Parameter PW_LEN, default 4: number of digits in a valid password entry.
REQ-002 Parameter CNT_W, default 3: width of counter; SHALL satisfy 2^CNT_W > PW_LEN.
REQ-003 Parameter MAX_FAIL, default 3, range 1-15: failed compares that trigger lockout.
REQ-004 Parameter LOCKOUT_CYC, default 1000, minimum 1: lockout duration in clk cycles.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 enter  in  1  user request to store the password currently in the digit buffer.
REQ-008 delete  in  1  user request to erase the stored password.
REQ-009 lock  in  1  user request to re-lock.
REQ-010 counter  in  CNT_W  digits currently held in the entry buffer.
REQ-011 saver_done, deleter_done, comparator_done  in  1 each  completion strobes from the saver, deleter and comparator.
REQ-012 match  in  1  comparator result; valid only while comparator_done=1.
REQ-013 error_open  in  1  door-sensor fault; meaningful only in OPEN.
REQ-014 save_start, delete_start, compare_start  out  1 each  one-cycle start pulses.
REQ-015 unlock  out  1  high while the lock is open.
REQ-016 error  out  1  error indication.
REQ-017 locked_out  out  1  high during a lockout.
REQ-018 fail_count  out  4  consecutive failed compares.

Function
REQ-019 States SHALL be EMPTY, SAVE, OPEN, DELETE, LOCKED, COMPARE and LOCKOUT; all outputs SHALL be registered.
REQ-020 EMPTY: enter with counter==PW_LEN -> SAVE; enter with counter!=PW_LEN -> stay, error pulses for one cycle.
REQ-021 SAVE: save_start high in the first SAVE cycle only; saver_done -> OPEN.
REQ-022 OPEN: unlock=1; error follows error_open with 1-cycle latency.
REQ-023 OPEN priority SHALL be lock > delete > enter: lock -> LOCKED; delete with counter==PW_LEN -> DELETE; enter with counter==PW_LEN -> SAVE (password change).
REQ-024 OPEN: lock SHALL be ignored while error_open=1.
REQ-025 DELETE: delete_start high in the first cycle only; deleter_done -> EMPTY.
REQ-026 LOCKED: a compare SHALL be triggered only on the cycle counter changes to PW_LEN from any other value; a held counter==PW_LEN SHALL NOT retrigger. The trigger moves to COMPARE, and compare_start is high in the first cycle only.
REQ-027 COMPARE: comparator_done with match=1 -> OPEN and clears fail_count.
REQ-028 COMPARE: comparator_done with match=0 increments fail_count, then goes to LOCKOUT if the new value equals MAX_FAIL, else to LOCKED.
REQ-029 LOCKOUT: locked_out=1; counter, enter, delete and lock are ignored; the timer runs exactly LOCKOUT_CYC cycles, then the state goes to LOCKED and fail_count clears.
REQ-030 A done strobe arriving in a state that does not await it SHALL be ignored.
REQ-031 Start pulses SHALL assert exactly one cycle after the triggering input is sampled.

Reset
REQ-032 reset SHALL force EMPTY, clear fail_count and the lockout timer, and drive all outputs to 0.
REQ-033 reset asserted mid-operation (SAVE, DELETE, COMPARE or LOCKOUT) SHALL abandon the operation without emitting any pulse.
REQ-034 The counter edge history SHALL reset to 0, so counter==PW_LEN on the first cycle after reset is treated as a rising edge.

Configuration
REQ-035 With LOCK_LOCKOUT_EN defined: lockout behaves per REQ-028/029.
REQ-036 Without LOCK_LOCKOUT_EN: no LOCKOUT state or timer; failures return to LOCKED; fail_count saturates at 15; locked_out is tied to 0.

Verification (PW_LEN=4, MAX_FAIL=3, LOCKOUT_CYC=8)
REQ-037 Reset, counter=4, enter pulse, saver_done after 2 cycles -> save_start one cycle, then unlock=1.
REQ-038 In OPEN, lock and delete asserted together -> LOCKED, unlock=0, no delete_start.
REQ-039 In LOCKED, counter 3->4 held 5 cycles -> exactly one compare_start; comparator_done with match=1 -> unlock=1, fail_count=0.
REQ-040 Three mismatches (macro defined) -> fail_count=3, locked_out=1 for 8 cycles, counter edges ignored, then LOCKED with fail_count=0.
REQ-041 In OPEN, error_open=1 -> error=1 next cycle and lock ignored; then delete with counter=4 and deleter_done -> EMPTY.
REQ-042 reset during COMPARE -> EMPTY next cycle, all outputs 0, and a late comparator_done is ignored.
